// File: rtl/sram_arbiter.sv
// Two-port arbiter sharing one asynchronous 16-bit SRAM between the debug port and the CPU bus.
// Latency: request sampled in IDLE -> ack in the WAIT+2th cycle after it; one access per WAIT+3 cycles.
// Backpressure: requesters hold req and operands until their one-cycle ack; the loser stays pending.
module sram_arbiter #(
    parameter int WAIT     = 3,
    parameter bit DBG_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_req,
    input  logic [15:0] d_addr,
    input  logic        d_r,
    input  logic [1:0]  d_w,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_ack,
    input  logic        c_req,
    input  logic [15:0] c_addr,
    input  logic        c_r,
    input  logic [1:0]  c_w,
    input  logic [15:0] c_wdata,
    output logic [15:0] c_rdata,
    output logic        c_ack,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_o,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_i,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n,
    output logic        busy,
    output logic        grant
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        op_rd;
    logic [1:0]  be;
    logic        d_vld, c_vld, pick_d, acc;
    logic        unused_addr_lsb;

    assign d_vld = d_req && (d_r || (d_w != 2'b00));
    assign c_vld = c_req && (c_r || (c_w != 2'b00));
    // grant doubles as last_grant: on a tie the port that did not own the last access wins
    assign pick_d = d_vld && (!c_vld || DBG_PRIO || !grant);
    assign unused_addr_lsb = d_addr[0] ^ c_addr[0];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (d_vld || c_vld) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (cnt == 4'd0) state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            op_rd     <= 1'b0;
            be        <= 2'b00;
            grant     <= 1'b0;
            sram_addr <= 18'd0;
            sram_dq_o <= 16'd0;
            d_rdata   <= 16'd0;
            c_rdata   <= 16'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (d_vld || c_vld) begin
                        grant     <= pick_d;
                        op_rd     <= pick_d ? d_r : c_r;
                        be        <= pick_d ? d_w : c_w;
                        sram_addr <= {3'b000, pick_d ? d_addr[15:1] : c_addr[15:1]};
                        if (!(pick_d ? d_r : c_r))
                            sram_dq_o <= pick_d ? d_wdata : c_wdata;
                    end
                end
                SETUP: cnt <= 4'(WAIT - 1);
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (op_rd && grant)  d_rdata <= sram_dq_i;
                        if (op_rd && !grant) c_rdata <= sram_dq_i;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign acc        = (state == ACCESS);
    assign busy       = (state != IDLE);
    assign d_ack      = (state == HOLD) && grant;
    assign c_ack      = (state == HOLD) && !grant;
    assign sram_ce_n  = (state == IDLE);
    assign sram_oe_n  = !(acc && op_rd);
    assign sram_we_n  = !(acc && !op_rd);
    assign sram_ub_n  = !(acc && (op_rd || be[1]));
    assign sram_lb_n  = !(acc && (op_rd || be[0]));
    // write data stays on the pad from SETUP through HOLD for address/data hold time
    assign sram_dq_oe = busy && !op_rd;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: vector table, directed corner sequences, random vs. timing model.
module tb_sram_arbiter;

    typedef struct packed {
        logic [15:0] d_rdata;
        logic        d_ack;
        logic [15:0] c_rdata;
        logic        c_ack;
        logic [17:0] addr;
        logic [15:0] dq_o;
        logic        dq_oe, ce_n, oe_n, we_n, ub_n, lb_n, busy, grant;
    } out_t;

    typedef struct {
        int k;
        bit dq; bit dr; logic [1:0] dw;
        bit cq; bit cr; logic [1:0] cw;
        bit e_busy; bit e_grant; bit e_oe;
    } vec_t;

    logic clk, reset;
    logic d_req, d_r, c_req, c_r;
    logic [1:0] d_w, c_w;
    logic [15:0] d_addr, c_addr, d_wdata, c_wdata, dq_i;

    logic [15:0] d_rdata_w [3];
    logic [15:0] c_rdata_w [3];
    logic [15:0] dq_o_w [3];
    logic [17:0] addr_w [3];
    logic d_ack_w [3], c_ack_w [3], dq_oe_w [3], ce_n_w [3], oe_n_w [3];
    logic we_n_w [3], ub_n_w [3], lb_n_w [3], busy_w [3], grant_w [3];

    int n_chk = 0;
    int n_err = 0;
    int wv [3];
    bit pv [3];

    sram_arbiter #(.WAIT(3), .DBG_PRIO(1'b0)) u0 (
        .clk(clk), .reset(reset),
        .d_req(d_req), .d_addr(d_addr), .d_r(d_r), .d_w(d_w), .d_wdata(d_wdata),
        .d_rdata(d_rdata_w[0]), .d_ack(d_ack_w[0]),
        .c_req(c_req), .c_addr(c_addr), .c_r(c_r), .c_w(c_w), .c_wdata(c_wdata),
        .c_rdata(c_rdata_w[0]), .c_ack(c_ack_w[0]),
        .sram_addr(addr_w[0]), .sram_dq_o(dq_o_w[0]), .sram_dq_oe(dq_oe_w[0]), .sram_dq_i(dq_i),
        .sram_ce_n(ce_n_w[0]), .sram_oe_n(oe_n_w[0]), .sram_we_n(we_n_w[0]),
        .sram_ub_n(ub_n_w[0]), .sram_lb_n(lb_n_w[0]), .busy(busy_w[0]), .grant(grant_w[0]));

    sram_arbiter #(.WAIT(3), .DBG_PRIO(1'b1)) u1 (
        .clk(clk), .reset(reset),
        .d_req(d_req), .d_addr(d_addr), .d_r(d_r), .d_w(d_w), .d_wdata(d_wdata),
        .d_rdata(d_rdata_w[1]), .d_ack(d_ack_w[1]),
        .c_req(c_req), .c_addr(c_addr), .c_r(c_r), .c_w(c_w), .c_wdata(c_wdata),
        .c_rdata(c_rdata_w[1]), .c_ack(c_ack_w[1]),
        .sram_addr(addr_w[1]), .sram_dq_o(dq_o_w[1]), .sram_dq_oe(dq_oe_w[1]), .sram_dq_i(dq_i),
        .sram_ce_n(ce_n_w[1]), .sram_oe_n(oe_n_w[1]), .sram_we_n(we_n_w[1]),
        .sram_ub_n(ub_n_w[1]), .sram_lb_n(lb_n_w[1]), .busy(busy_w[1]), .grant(grant_w[1]));

    sram_arbiter #(.WAIT(1), .DBG_PRIO(1'b0)) u2 (
        .clk(clk), .reset(reset),
        .d_req(d_req), .d_addr(d_addr), .d_r(d_r), .d_w(d_w), .d_wdata(d_wdata),
        .d_rdata(d_rdata_w[2]), .d_ack(d_ack_w[2]),
        .c_req(c_req), .c_addr(c_addr), .c_r(c_r), .c_w(c_w), .c_wdata(c_wdata),
        .c_rdata(c_rdata_w[2]), .c_ack(c_ack_w[2]),
        .sram_addr(addr_w[2]), .sram_dq_o(dq_o_w[2]), .sram_dq_oe(dq_oe_w[2]), .sram_dq_i(dq_i),
        .sram_ce_n(ce_n_w[2]), .sram_oe_n(oe_n_w[2]), .sram_we_n(we_n_w[2]),
        .sram_ub_n(ub_n_w[2]), .sram_lb_n(lb_n_w[2]), .busy(busy_w[2]), .grant(grant_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic out_t get(input int k);
        out_t r;
        r.d_rdata = d_rdata_w[k]; r.d_ack = d_ack_w[k];
        r.c_rdata = c_rdata_w[k]; r.c_ack = c_ack_w[k];
        r.addr = addr_w[k]; r.dq_o = dq_o_w[k]; r.dq_oe = dq_oe_w[k];
        r.ce_n = ce_n_w[k]; r.oe_n = oe_n_w[k]; r.we_n = we_n_w[k];
        r.ub_n = ub_n_w[k]; r.lb_n = lb_n_w[k]; r.busy = busy_w[k]; r.grant = grant_w[k];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_o(input string nm, input out_t act, input out_t exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        d_req = 0; d_r = 0; d_w = 2'b00; d_addr = 16'h0; d_wdata = 16'h0;
        c_req = 0; c_r = 0; c_w = 2'b00; c_addr = 16'h0; c_wdata = 16'h0;
        dq_i = 16'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- timing reference model ----------------
    // An access granted in idle cycle s occupies cycles s+1 (setup), s+2..s+W+1 (strobes), s+W+2 (ack).
    bit          m_act, m_rd, m_grant;
    logic [1:0]  m_be;
    logic [17:0] m_addr;
    logic [15:0] m_dq, m_drd, m_crd;
    int          m_start, cyc;

    task automatic m_clear();
        m_act = 0; m_rd = 0; m_grant = 0; m_be = 2'b00;
        m_addr = '0; m_dq = '0; m_drd = '0; m_crd = '0; cyc = 0; m_start = 0;
    endtask

    task automatic m_step(input int w, input bit p);
        bit dv, cv, win;
        logic [15:0] a;
        if (reset) begin
            m_clear();
        end else if (!m_act) begin
            dv = d_req && (d_r || d_w != 2'b00);
            cv = c_req && (c_r || c_w != 2'b00);
            if (dv || cv) begin
                win = dv && (!cv || p || !m_grant);
                m_grant = win; m_act = 1; m_start = cyc;
                m_rd = win ? d_r : c_r;
                m_be = win ? d_w : c_w;
                a = win ? d_addr : c_addr;
                m_addr = {3'b000, a[15:1]};
                if (!m_rd) m_dq = win ? d_wdata : c_wdata;
            end
        end else begin
            if ((cyc - m_start) == w + 1 && m_rd) begin
                if (m_grant) m_drd = dq_i; else m_crd = dq_i;
            end
            if ((cyc - m_start) == w + 2) m_act = 0;
        end
        cyc++;
    endtask

    function automatic out_t m_exp(input int w);
        out_t e;
        int p;
        bit a;
        e = '0;
        e.d_rdata = m_drd; e.c_rdata = m_crd; e.addr = m_addr; e.dq_o = m_dq; e.grant = m_grant;
        e.ce_n = 1; e.oe_n = 1; e.we_n = 1; e.ub_n = 1; e.lb_n = 1;
        if (m_act) begin
            p = cyc - m_start;
            a = (p >= 2) && (p <= w + 1);
            e.busy = 1; e.ce_n = 0; e.dq_oe = !m_rd;
            e.oe_n = !(a && m_rd);
            e.we_n = !(a && !m_rd);
            e.ub_n = !(a && (m_rd || m_be[1]));
            e.lb_n = !(a && (m_rd || m_be[0]));
            e.d_ack = (p == w + 2) && m_grant;
            e.c_ack = (p == w + 2) && !m_grant;
        end
        return e;
    endfunction

    task automatic drive_port(input logic ack, inout logic req, inout logic r, inout logic [1:0] w,
                              inout logic [15:0] a, inout logic [15:0] wd, inout bit pend, inout int inv);
        if (ack) begin
            req = 0; pend = 0;
        end else if (inv > 0) begin
            inv--;
            if (inv == 0) req = 0;
        end else if (!pend && $urandom_range(0, 3) == 0) begin
            req = 1; a = 16'($urandom); wd = 16'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                r = 0; w = 2'b00; inv = $urandom_range(1, 3);
            end else begin
                pend = 1;
                r = 1'($urandom_range(0, 1));
                w = r ? 2'($urandom) : 2'($urandom_range(1, 3));
            end
        end
    endtask

    // ---------------- two-port service loop for arbitration sequences ----------------
    int ack_port [$];
    int ack_t [$];

    task automatic serve(input int k, input int nacks, input int d_lim, input int c_lim);
        int t, dn, cn;
        bit d_re, c_re;
        out_t o;
        t = 0; dn = 0; cn = 0; d_re = 0; c_re = 0;
        ack_port.delete(); ack_t.delete();
        while (ack_port.size() < nacks && t < 100) begin
            @(negedge clk);
            t++;
            o = get(k);
            if (d_re) begin d_req = 1; d_re = 0; end
            if (c_re) begin c_req = 1; c_re = 0; end
            if (o.d_ack) begin
                ack_port.push_back(1); ack_t.push_back(t);
                d_req = 0; dn++; d_re = (dn < d_lim);
            end
            if (o.c_ack) begin
                ack_port.push_back(0); ack_t.push_back(t);
                c_req = 0; cn++; c_re = (cn < c_lim);
            end
        end
        chk("serve_ack_count", ack_port.size(), nacks);
    endtask

    vec_t tv [9];
    out_t o, e, rst_exp;
    bit d_pend, c_pend;
    int d_inv, c_inv;

    initial begin
        reset = 1'b1;
        wv = '{3, 3, 1};
        pv = '{1'b0, 1'b1, 1'b0};
        //            k  dq dr dw     cq cr cw     busy grant oe
        tv[0] = '{0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0};
        tv[1] = '{0, 1, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0};
        tv[2] = '{0, 1, 1, 2'b00, 0, 0, 2'b00, 1, 1, 0};
        tv[3] = '{0, 0, 0, 2'b00, 1, 0, 2'b01, 1, 0, 1};
        tv[4] = '{0, 1, 1, 2'b00, 1, 1, 2'b00, 1, 1, 0};
        tv[5] = '{1, 1, 0, 2'b10, 1, 1, 2'b00, 1, 1, 1};
        tv[6] = '{0, 1, 0, 2'b00, 1, 1, 2'b00, 1, 0, 0};
        tv[7] = '{0, 1, 1, 2'b11, 0, 0, 2'b00, 1, 1, 0};
        tv[8] = '{2, 0, 0, 2'b00, 1, 1, 2'b11, 1, 0, 0};

        do_reset();
        rst_exp = '0;
        rst_exp.ce_n = 1; rst_exp.oe_n = 1; rst_exp.we_n = 1; rst_exp.ub_n = 1; rst_exp.lb_n = 1;
        for (int k = 0; k < 3; k++) chk_o("reset_state", get(k), rst_exp);

        // one-cycle arbitration / op decode table, checked in the SETUP cycle
        for (int i = 0; i < 9; i++) begin
            do_reset();
            d_req = tv[i].dq; d_r = tv[i].dr; d_w = tv[i].dw; d_addr = 16'h0100;
            c_req = tv[i].cq; c_r = tv[i].cr; c_w = tv[i].cw; c_addr = 16'h0200;
            @(negedge clk);
            o = get(tv[i].k);
            chk($sformatf("vec%0d_busy", i), o.busy, tv[i].e_busy);
            chk($sformatf("vec%0d_grant", i), o.grant, tv[i].e_grant);
            chk($sformatf("vec%0d_dq_oe", i), o.dq_oe, tv[i].e_oe);
        end

        // cpu read, WAIT=3
        begin
            int ack_at, oe_low, dacks;
            logic [17:0] a1;
            do_reset();
            c_req = 1; c_r = 1; c_w = 2'b00; c_addr = 16'h4002; dq_i = 16'hBEEF;
            ack_at = -1; oe_low = 0; dacks = 0; a1 = '0;
            for (int t = 1; t <= 8; t++) begin
                @(negedge clk);
                o = get(0);
                if (t == 1) a1 = o.addr;
                if (!o.oe_n) oe_low++;
                if (o.d_ack) dacks++;
                if (o.c_ack) begin
                    if (ack_at < 0) ack_at = t;
                    c_req = 0;
                end
            end
            chk("rd_addr", a1, 18'h02001);
            chk("rd_oe_cycles", oe_low, 3);
            chk("rd_ack_cycle", ack_at, 5);
            chk("rd_rdata", get(0).c_rdata, 16'hBEEF);
            chk("rd_no_dack", dacks, 0);
        end

        // dbg upper-byte write, WAIT=3
        begin
            int we_low, oe_cnt, oe_first, acks;
            bit lanes_bad;
            logic [15:0] dqo;
            do_reset();
            d_req = 1; d_r = 0; d_w = 2'b10; d_addr = 16'h0010; d_wdata = 16'h12AB;
            we_low = 0; oe_cnt = 0; oe_first = -1; acks = 0; lanes_bad = 0; dqo = '0;
            for (int t = 1; t <= 8; t++) begin
                @(negedge clk);
                o = get(0);
                if (t == 1) dqo = o.dq_o;
                if (!o.we_n) begin
                    we_low++;
                    if (o.ub_n !== 1'b0 || o.lb_n !== 1'b1) lanes_bad = 1;
                end
                if (o.dq_oe) begin
                    oe_cnt++;
                    if (oe_first < 0) oe_first = t;
                end
                if (o.d_ack) begin acks++; d_req = 0; end
            end
            chk("wr_we_cycles", we_low, 3);
            chk("wr_lanes_bad", lanes_bad, 0);
            chk("wr_dq_oe_cycles", oe_cnt, 5);
            chk("wr_dq_oe_first", oe_first, 1);
            chk("wr_dq_o", dqo, 16'h12AB);
            chk("wr_ack_pulses", acks, 1);
        end

        // round robin: simultaneous first requests, each re-requesting
        do_reset();
        d_req = 1; d_r = 1; d_addr = 16'h0002;
        c_req = 1; c_r = 1; c_addr = 16'h0004;
        serve(0, 4, 2, 2);
        for (int i = 0; i < ack_port.size(); i++)
            chk($sformatf("rr_port%0d", i), ack_port[i], (i % 2 == 0) ? 1 : 0);
        for (int i = 1; i < ack_t.size(); i++)
            chk($sformatf("rr_gap%0d", i), ack_t[i] - ack_t[i-1], 6);
        if (ack_t.size() > 0) chk("rr_first_ack", ack_t[0], 5);

        // fixed dbg priority starves cpu until dbg stops
        do_reset();
        d_req = 1; d_r = 1; d_addr = 16'h0002;
        c_req = 1; c_r = 1; c_addr = 16'h0004;
        serve(1, 4, 3, 1);
        for (int i = 0; i < ack_port.size(); i++)
            chk($sformatf("prio_port%0d", i), ack_port[i], (i < 3) ? 1 : 0);
        if (ack_t.size() == 4) chk("prio_cpu_gap", ack_t[3] - ack_t[2], 6);

        // reset in the 2nd strobe cycle of a write, then a clean read
        begin
            int acks, ack_at;
            do_reset();
            d_req = 1; d_r = 0; d_w = 2'b11; d_addr = 16'h0020; d_wdata = 16'hA5A5;
            repeat (3) @(negedge clk);
            chk("rst_mid_we_active", get(0).we_n, 1'b0);
            reset = 1;
            @(negedge clk);
            o = get(0);
            chk("rst_mid_we_n", o.we_n, 1'b1);
            chk("rst_mid_ce_n", o.ce_n, 1'b1);
            chk("rst_mid_dq_oe", o.dq_oe, 1'b0);
            chk("rst_mid_busy", o.busy, 1'b0);
            reset = 0; d_req = 0;
            acks = 0;
            for (int t = 0; t < 6; t++) begin
                @(negedge clk);
                if (get(0).d_ack) acks++;
            end
            chk("rst_mid_no_ack", acks, 0);
            d_req = 1; d_r = 1; d_w = 2'b00; d_addr = 16'h0030; dq_i = 16'h1357;
            ack_at = -1;
            for (int t = 1; t <= 8; t++) begin
                @(negedge clk);
                if (get(0).d_ack) begin
                    if (ack_at < 0) ack_at = t;
                    d_req = 0;
                end
            end
            chk("rst_after_ack_cycle", ack_at, 5);
            chk("rst_after_rdata", get(0).d_rdata, 16'h1357);
        end

        // WAIT=1: null request ignored, then valid read
        begin
            bit bad;
            int ack_at;
            do_reset();
            c_req = 1; c_r = 0; c_w = 2'b00;
            bad = 0;
            for (int t = 0; t < 10; t++) begin
                @(negedge clk);
                o = get(2);
                if (!o.ce_n || !o.oe_n || !o.we_n || o.busy || o.c_ack || o.d_ack) bad = 1;
            end
            chk("null_req_activity", bad, 0);
            c_r = 1; c_addr = 16'h00A0; dq_i = 16'h5A5A;
            ack_at = -1;
            for (int t = 1; t <= 6; t++) begin
                @(negedge clk);
                if (get(2).c_ack) begin
                    if (ack_at < 0) ack_at = t;
                    c_req = 0;
                end
            end
            chk("w1_ack_cycle", ack_at, 3);
            chk("w1_rdata", get(2).c_rdata, 16'h5A5A);
            chk("w1_addr", get(2).addr, 18'h00050);
        end

        // random traffic against the timing model, each configuration in turn
        for (int k = 0; k < 3; k++) begin
            do_reset();
            m_clear();
            d_pend = 0; c_pend = 0; d_inv = 0; c_inv = 0;
            for (int n = 0; n < 400; n++) begin
                @(posedge clk);
                m_step(wv[k], pv[k]);
                @(negedge clk);
                e = m_exp(wv[k]);
                chk_o($sformatf("random_u%0d", k), get(k), e);
                reset = ($urandom_range(0, 149) == 0);
                dq_i = 16'($urandom);
                drive_port(e.d_ack, d_req, d_r, d_w, d_addr, d_wdata, d_pend, d_inv);
                drive_port(e.c_ack, c_req, c_r, c_w, c_addr, c_wdata, c_pend, c_inv);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the external asynchronous 16-bit SRAM between two requesters: the debug UART memory port (dbg) and the b16 CPU bus (cpu).
- Generates the SRAM strobes with a programmable number of wait states and returns one-cycle acknowledges.
- Replaces the ad-hoc csu mux and READY counter in the top level.
- Sits between those requesters and the top-level SRAM pins; the tristate buffer stays at top level.

Parameters:
WAIT, 3, ACCESS-state length in cycles (legal 1..15)
DBG_PRIO, 0, 1 = dbg always wins ties; 0 = round-robin between ports

Ports:
clk  in  1  system clock (CLOCK_50)
reset  in  1  synchronous, active-high reset
d_req  in  1  dbg request, level; held with d_addr/d_r/d_w/d_wdata stable until d_ack
d_addr  in  16  dbg byte address (bit 0 ignored)
d_r  in  1  dbg read
d_w  in  2  dbg byte write enables {hi,lo}
d_wdata  in  16  dbg write data
d_rdata  out  16  dbg read data, registered
d_ack  out  1  dbg acknowledge, one-cycle pulse
c_req, c_addr, c_r, c_w, c_wdata, c_rdata, c_ack  same widths and directions as the d_* signals  CPU port
sram_addr  out  18  {3'b000, addr[15:1]}
sram_dq_o  out  16  write data to pad
sram_dq_oe  out  1  pad output enable
sram_dq_i  in  16  read data from pad
sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  SRAM strobes, active low
busy  out  1  FSM not in IDLE
grant  out  1  owner of the current or last access: 1 = dbg, 0 = cpu

Behaviour:
Reset (sync, dominates all else):
- State IDLE; all *_n outputs 1; sram_dq_oe 0.
- sram_addr, sram_dq_o, d_rdata, c_rdata = 0; d_ack, c_ack, busy = 0.
- last_grant = cpu, so dbg wins the first tie. grant = 0.
- Reset asserted mid-access: strobes deassert on the next edge, no ack is issued, and the requester must reissue.

Request validity:
- Valid request = req & (r | |w).
- req with r=0 and w=00: ignored; never granted, never acked.
- r=1 with w!=0: treated as a read; w is ignored.

FSM states: IDLE -> SETUP -> ACCESS -> HOLD -> IDLE.
- IDLE, no valid request: all strobes high; sram_addr and sram_dq_o hold their last values.
- IDLE, valid request present:
  - Choose winner: single requester wins. On a tie, dbg wins if DBG_PRIO=1; otherwise the port that is not last_grant wins.
  - Latch winner's addr, op, byte enables and wdata; update grant and last_grant; go to SETUP.
- SETUP (1 cycle):
  - ce_n=0; sram_addr valid; oe_n=1, we_n=1.
  - Write: dq_oe=1 with data.
  - Load wait counter with WAIT-1.
- ACCESS (WAIT cycles):
  - Read: oe_n=0, ub_n=lb_n=0.
  - Write: we_n=0, ub_n=~w[1], lb_n=~w[0].
  - Counter decrements each cycle; leave when it reaches 0.
  - Read: sram_dq_i is captured into the winner's rdata on the last ACCESS edge.
- HOLD (1 cycle):
  - oe_n=we_n=1; ce_n=0; address and write data still driven (hold time).
  - Winner's ack=1; next state IDLE. dq_oe drops on the exit edge.
- Byte lanes are high whenever the FSM is not in ACCESS.

Latency:
- Request sampled in IDLE at edge k: ack is high in cycle k+2+WAIT. Throughput is one access per WAIT+3 cycles.
- A requester must drop req on the edge where it samples ack, or a new access starts.
- Back-to-back: in the IDLE cycle after HOLD, a pending request from the other port is granted with no gap.

rdata rules:
- Each port's rdata changes only on its own read captures. It holds across the other port's accesses and across writes.
- The losing port's req stays pending and is not acked.

Test Plan:
1. WAIT=3; cpu read addr 16'h4002, sram_dq_i=16'hBEEF -> sram_addr=18'h02001; oe_n low exactly 3 cycles; c_ack pulse 5 cycles after request sampled; c_rdata=16'hBEEF; d_ack stays 0.
2. dbg write addr 16'h0010, w=2'b10, wdata=16'h12AB -> we_n low 3 cycles, ub_n=0, lb_n=1; dq_oe high from SETUP through HOLD; sram_dq_o=16'h12AB; d_ack one pulse.
3. DBG_PRIO=0; d_req and c_req asserted in the same cycle after reset, each re-requesting after its ack -> grant sequence dbg, cpu, dbg, cpu; IDLE lasts one cycle between accesses.
4. DBG_PRIO=1; dbg re-requests continuously and cpu waits -> cpu never acked while dbg requests; cpu acked in the first access after d_req drops.
5. Reset pulsed during the 2nd ACCESS cycle of a write -> next cycle we_n=ce_n=1, dq_oe=0, no ack, busy=0; a subsequent read completes normally.
6. WAIT=1; c_req with r=0, w=00 for 10 cycles -> no strobes, busy=0, no ack. Then a valid read -> ack 3 cycles after request sampled.
